// File: rtl/register_file_sb_pkg.sv
// Shared definitions for the register_file_sb slice.
//   DEF_WIDTH / DEF_DEPTH : default data width and register count
//   addr_bits()           : select width for a given register count
//   cnt_bits()            : width needed to hold 0..depth inclusive
package register_file_sb_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// regfile_scoreboard: per-register pending bits, pending counter and
// operand-ready lookup for the register file.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous clear of all pending bits and the counter
//   write_en_i/sel_i    qualified write (address already range-checked)
//   reserve_en_i/sel_i  qualified reserve (address already range-checked)
//   a_sel_i, a_ok_i     read select A and whether it names a real register
//   b_sel_i, b_ok_i     read select B and whether it names a real register
//   a_ready_o/b_ready_o operand not pending (combinational, with bypass)
//   pending_cnt_o       number of pending registers
module regfile_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_bits(DEF_DEPTH),
    parameter int CNT_W  = cnt_bits(DEF_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              write_en_i,
    input  logic [ADDR_W-1:0] write_sel_i,
    input  logic              reserve_en_i,
    input  logic [ADDR_W-1:0] reserve_sel_i,
    input  logic [ADDR_W-1:0] a_sel_i,
    input  logic              a_ok_i,
    input  logic [ADDR_W-1:0] b_sel_i,
    input  logic              b_ok_i,
    output logic              a_ready_o,
    output logic              b_ready_o,
    output logic [CNT_W-1:0]  pending_cnt_o
);

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_new, clr_old;

    always_comb begin
        pend_d  = pend_q;
        set_new = 1'b0;
        clr_old = 1'b0;
        if (write_en_i) begin
            pend_d[write_sel_i] = 1'b0;
            clr_old             = pend_q[write_sel_i];
        end
        // Reserve applied after write: a new producer keeps the register pending.
        if (reserve_en_i) begin
            pend_d[reserve_sel_i] = 1'b1;
            set_new               = !pend_q[reserve_sel_i];
            if (write_en_i && (write_sel_i == reserve_sel_i)) begin
                clr_old = 1'b0;
            end
        end
        // Counter tracks the popcount of pend_q exactly, so it cannot overflow or wrap.
        cnt_d = cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
        if (clear_i) begin
            pend_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // A write to the selected register this cycle makes it ready, unless the
    // same register is being re-reserved in the same cycle.
    always_comb begin
        a_ready_o = 1'b1;
        b_ready_o = 1'b1;
        if (a_ok_i) begin
            a_ready_o = !pend_q[a_sel_i] ||
                        (write_en_i && (write_sel_i == a_sel_i) &&
                         !(reserve_en_i && (reserve_sel_i == a_sel_i)));
        end
        if (b_ok_i) begin
            b_ready_o = !pend_q[b_sel_i] ||
                        (write_en_i && (write_sel_i == b_sel_i) &&
                         !(reserve_en_i && (reserve_sel_i == b_sel_i)));
        end
    end

    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: two-read/one-write register file with write-through
// bypass, optional registered read ports and a pending scoreboard.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   clear                          synchronous clear of data and pending bits
//   replaceEn/Sel/Data             write port
//   reserveEn/Sel                  mark a register pending
//   A_sel, B_sel                   read selects
//   A, B, A_ready, B_ready         read data and operand-ready flags
//   pending_cnt                    number of pending registers
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int REG_OUT  = 0,
    parameter  int ZERO_REG = 0,
    localparam int ADDR_W   = addr_bits(DEPTH),
    localparam int CNT_W    = cnt_bits(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              replaceEn,
    input  logic [ADDR_W-1:0] replaceSel,
    input  logic [WIDTH-1:0]  replaceData,
    input  logic              reserveEn,
    input  logic [ADDR_W-1:0] reserveSel,
    input  logic [ADDR_W-1:0] A_sel,
    input  logic [ADDR_W-1:0] B_sel,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic              A_ready,
    output logic              B_ready,
    output logic [CNT_W-1:0]  pending_cnt
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // A select names a real register: in range, and not the hard-wired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] sel);
        return ({1'b0, sel} < DEPTH_LIM) && !((ZERO_REG != 0) && (sel == '0));
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             write_ok, reserve_ok, a_ok, b_ok;
    logic [WIDTH-1:0] a_d, b_d;
    logic             a_rdy_d, b_rdy_d;

    assign write_ok   = replaceEn && addr_ok(replaceSel);
    assign reserve_ok = reserveEn && addr_ok(reserveSel);
    assign a_ok       = addr_ok(A_sel);
    assign b_ok       = addr_ok(B_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (write_ok) begin
            mem_q[replaceSel] <= replaceData;
        end
    end

    // Write-through bypass: a read of the register being written sees the new data.
    always_comb begin
        a_d = '0;
        b_d = '0;
        if (a_ok) a_d = (write_ok && (replaceSel == A_sel)) ? replaceData : mem_q[A_sel];
        if (b_ok) b_d = (write_ok && (replaceSel == B_sel)) ? replaceData : mem_q[B_sel];
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .write_en_i    (write_ok),
        .write_sel_i   (replaceSel),
        .reserve_en_i  (reserve_ok),
        .reserve_sel_i (reserveSel),
        .a_sel_i       (A_sel),
        .a_ok_i        (a_ok),
        .b_sel_i       (B_sel),
        .b_ok_i        (b_ok),
        .a_ready_o     (a_rdy_d),
        .b_ready_o     (b_rdy_d),
        .pending_cnt_o (pending_cnt)
    );

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] a_q, b_q;
            logic             a_rdy_q, b_rdy_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    a_rdy_q <= 1'b1;
                    b_rdy_q <= 1'b1;
                end else if (clear) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    a_rdy_q <= 1'b1;
                    b_rdy_q <= 1'b1;
                end else begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    a_rdy_q <= a_rdy_d;
                    b_rdy_q <= b_rdy_d;
                end
            end

            assign A       = a_q;
            assign B       = b_q;
            assign A_ready = a_rdy_q;
            assign B_ready = b_rdy_q;
        end else begin : g_comb_out
            assign A       = a_d;
            assign B       = b_d;
            assign A_ready = a_rdy_d;
            assign B_ready = b_rdy_d;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb. Three instances share one stimulus stream:
//   inst 0: REG_OUT=0, ZERO_REG=0   inst 1: REG_OUT=1   inst 2: ZERO_REG=1
// The driver pushes expected {A,B,A_ready,B_ready,pending_cnt} tuples tagged
// with the cycle they are due; the monitor pops and compares on the falling edge.
module tb_register_file_sb;

    localparam int W  = 8;
    localparam int AW = 4;
    localparam int CW = 5;
    localparam int EW = 2 * W + 2 + CW;

    typedef struct {
        int            inst;
        int            due;
        string         tag;
        logic [EW-1:0] exp;
    } chk_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          replaceEn;
    logic [AW-1:0] replaceSel;
    logic [W-1:0]  replaceData;
    logic          reserveEn;
    logic [AW-1:0] reserveSel;
    logic [AW-1:0] A_sel, B_sel;

    logic [W-1:0]  a0, b0, a1, b1, a2, b2;
    logic          ar0, br0, ar1, br1, ar2, br2;
    logic [CW-1:0] c0, c1, c2;

    chk_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    register_file_sb #(.WIDTH(W), .DEPTH(16), .REG_OUT(0), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .replaceEn(replaceEn),
        .replaceSel(replaceSel), .replaceData(replaceData), .reserveEn(reserveEn),
        .reserveSel(reserveSel), .A_sel(A_sel), .B_sel(B_sel), .A(a0), .B(b0),
        .A_ready(ar0), .B_ready(br0), .pending_cnt(c0));

    register_file_sb #(.WIDTH(W), .DEPTH(16), .REG_OUT(1), .ZERO_REG(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .replaceEn(replaceEn),
        .replaceSel(replaceSel), .replaceData(replaceData), .reserveEn(reserveEn),
        .reserveSel(reserveSel), .A_sel(A_sel), .B_sel(B_sel), .A(a1), .B(b1),
        .A_ready(ar1), .B_ready(br1), .pending_cnt(c1));

    register_file_sb #(.WIDTH(W), .DEPTH(16), .REG_OUT(0), .ZERO_REG(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .replaceEn(replaceEn),
        .replaceSel(replaceSel), .replaceData(replaceData), .reserveEn(reserveEn),
        .reserveSel(reserveSel), .A_sel(A_sel), .B_sel(B_sel), .A(a2), .B(b2),
        .A_ready(ar2), .B_ready(br2), .pending_cnt(c2));

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear       = 1'b0;
        replaceEn   = 1'b0;
        replaceSel  = '0;
        replaceData = '0;
        reserveEn   = 1'b0;
        reserveSel  = '0;
    endtask

    task automatic sel(input logic [AW-1:0] a, input logic [AW-1:0] b);
        A_sel = a;
        B_sel = b;
    endtask

    // lat = 0: due this cycle; lat = 1: due after the next rising edge.
    task automatic expect_out(input int inst, input int lat, input string tag,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ar, input logic br, input logic [CW-1:0] cnt);
        chk_t c;
        c.inst = inst;
        c.due  = cyc + lat;
        c.tag  = tag;
        c.exp  = {a, b, ar, br, cnt};
        exp_q.push_back(c);
    endtask

    // ---------------- monitor / scoreboard ----------------
    function automatic logic [EW-1:0] observe(input int inst);
        case (inst)
            0:       return {a0, b0, ar0, br0, c0};
            1:       return {a1, b1, ar1, br1, c1};
            default: return {a2, b2, ar2, br2, c2};
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        int i;
        logic [EW-1:0] got;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].due == cyc) begin
                got = observe(exp_q[i].inst);
                n_checks++;
                if (got !== exp_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s inst%0d cyc%0d: got A=%h B=%h Ar=%b Br=%b cnt=%0d, want A=%h B=%h Ar=%b Br=%b cnt=%0d",
                             exp_q[i].tag, exp_q[i].inst, cyc,
                             got[EW-1 -: W], got[EW-W-1 -: W], got[CW+1], got[CW], got[CW-1:0],
                             exp_q[i].exp[EW-1 -: W], exp_q[i].exp[EW-W-1 -: W],
                             exp_q[i].exp[CW+1], exp_q[i].exp[CW], exp_q[i].exp[CW-1:0]);
                end
                exp_q.delete(i);
            end else if (exp_q[i].due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s inst%0d: expectation missed its cycle %0d", exp_q[i].tag,
                         exp_q[i].inst, exp_q[i].due);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        rst_n = 1'b0;
        idle();
        sel(4'd0, 4'd0);
        repeat (2) cycle();
        rst_n = 1'b1;

        // 1. defaults after reset
        for (int i = 0; i < 16; i++) begin
            sel(AW'(i), AW'(15 - i));
            expect_out(0, 0, "reset_defaults", 8'h00, 8'h00, 1, 1, 0);
            expect_out(1, 1, "reset_defaults", 8'h00, 8'h00, 1, 1, 0);
            expect_out(2, 0, "reset_defaults", 8'h00, 8'h00, 1, 1, 0);
            cycle();
        end

        // 2. plain writes then reads
        replaceEn = 1; replaceSel = 4'd0; replaceData = 8'hAA; cycle();
        replaceSel = 4'd1; replaceData = 8'hBB; cycle();
        idle(); sel(4'd1, 4'd0);
        expect_out(0, 0, "write_read", 8'hBB, 8'hAA, 1, 1, 0);
        expect_out(1, 1, "write_read", 8'hBB, 8'hAA, 1, 1, 0);
        expect_out(2, 0, "zero_reg_write", 8'hBB, 8'h00, 1, 1, 0);
        cycle();

        // 3. write-through bypass
        replaceEn = 1; replaceSel = 4'hF; replaceData = 8'hDD; sel(4'hF, 4'd1);
        expect_out(0, 0, "bypass", 8'hDD, 8'hBB, 1, 1, 0);
        expect_out(1, 1, "bypass", 8'hDD, 8'hBB, 1, 1, 0);
        expect_out(2, 0, "bypass", 8'hDD, 8'hBB, 1, 1, 0);
        cycle();

        // 4. reserve / writeback
        idle(); reserveEn = 1; reserveSel = 4'd2; sel(4'd2, 4'hF);
        expect_out(0, 0, "reserve_issue", 8'h00, 8'hDD, 1, 1, 0);
        expect_out(1, 1, "reserve_issue", 8'h00, 8'hDD, 1, 1, 1);
        cycle();
        idle();
        expect_out(0, 0, "pending", 8'h00, 8'hDD, 0, 1, 1);
        expect_out(1, 1, "pending", 8'h00, 8'hDD, 0, 1, 1);
        cycle();
        replaceEn = 1; replaceSel = 4'd2; replaceData = 8'hCC;
        expect_out(0, 0, "writeback_bypass", 8'hCC, 8'hDD, 1, 1, 1);
        expect_out(1, 1, "writeback_bypass", 8'hCC, 8'hDD, 1, 1, 0);
        cycle();
        idle();
        expect_out(0, 0, "writeback_done", 8'hCC, 8'hDD, 1, 1, 0);
        expect_out(1, 1, "writeback_done", 8'hCC, 8'hDD, 1, 1, 0);
        cycle();
        replaceEn = 1; replaceSel = 4'd2; replaceData = 8'h11; reserveEn = 1; reserveSel = 4'd2;
        expect_out(0, 0, "reserve_write_same", 8'h11, 8'hDD, 1, 1, 0);
        expect_out(1, 1, "reserve_write_same", 8'h11, 8'hDD, 1, 1, 1);
        cycle();
        idle();
        expect_out(0, 0, "new_producer_wins", 8'h11, 8'hDD, 0, 1, 1);
        expect_out(1, 1, "new_producer_wins", 8'h11, 8'hDD, 0, 1, 1);
        cycle();
        reserveEn = 1; reserveSel = 4'd2;
        expect_out(0, 0, "re_reserve", 8'h11, 8'hDD, 0, 1, 1);
        expect_out(1, 1, "re_reserve", 8'h11, 8'hDD, 0, 1, 1);
        cycle();

        // 5. multi-reserve, clear, async reset
        reserveSel = 4'd3; cycle();
        reserveSel = 4'd4; cycle();
        reserveSel = 4'd5; cycle();
        idle(); sel(4'd3, 4'd5);
        expect_out(0, 0, "multi_pending", 8'h00, 8'h00, 0, 0, 4);
        expect_out(1, 1, "multi_pending", 8'h00, 8'h00, 0, 0, 4);
        cycle();
        clear = 1; replaceEn = 1; replaceSel = 4'd3; replaceData = 8'h77;
        reserveEn = 1; reserveSel = 4'd6; sel(4'd2, 4'd3);
        expect_out(0, 0, "pre_clear", 8'h11, 8'h77, 0, 1, 4);
        expect_out(1, 1, "clear_out", 8'h00, 8'h00, 1, 1, 0);
        cycle();
        idle(); sel(4'd2, 4'hF);
        expect_out(0, 0, "after_clear", 8'h00, 8'h00, 1, 1, 0);
        expect_out(1, 1, "after_clear", 8'h00, 8'h00, 1, 1, 0);
        expect_out(2, 0, "after_clear", 8'h00, 8'h00, 1, 1, 0);
        cycle();
        replaceEn = 1; replaceSel = 4'd1; replaceData = 8'h55; cycle();
        idle(); sel(4'd1, 4'd7);
        expect_out(0, 0, "pre_reset", 8'h55, 8'h00, 1, 1, 0);
        cycle();
        rst_n = 0; reserveEn = 1; reserveSel = 4'd7;
        replaceEn = 1; replaceSel = 4'd8; replaceData = 8'h99;
        expect_out(0, 0, "async_reset", 8'h00, 8'h00, 1, 1, 0);
        expect_out(1, 0, "async_reset", 8'h00, 8'h00, 1, 1, 0);
        expect_out(2, 0, "async_reset", 8'h00, 8'h00, 1, 1, 0);
        cycle();
        rst_n = 1; idle(); sel(4'd8, 4'd7);
        expect_out(0, 0, "write_discarded", 8'h00, 8'h00, 1, 1, 0);
        expect_out(1, 0, "reset_held_out", 8'h00, 8'h00, 1, 1, 0);
        expect_out(1, 1, "write_discarded", 8'h00, 8'h00, 1, 1, 0);
        cycle();

        // 6. zero register
        replaceEn = 1; replaceSel = 4'd0; replaceData = 8'hEE;
        reserveEn = 1; reserveSel = 4'd0; sel(4'd0, 4'd0);
        expect_out(0, 0, "r0_normal_bypass", 8'hEE, 8'hEE, 1, 1, 0);
        expect_out(1, 1, "r0_normal_bypass", 8'hEE, 8'hEE, 1, 1, 1);
        expect_out(2, 0, "r0_zero_bypass", 8'h00, 8'h00, 1, 1, 0);
        cycle();
        idle();
        expect_out(0, 0, "r0_normal_pending", 8'hEE, 8'hEE, 0, 0, 1);
        expect_out(1, 1, "r0_normal_pending", 8'hEE, 8'hEE, 0, 0, 1);
        expect_out(2, 0, "r0_zero_never_pending", 8'h00, 8'h00, 1, 1, 0);
        cycle();

        // drain: bounded wait for the scoreboard to empty
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) cycle();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
